// File: rtl/display_clock_supervisor.sv
// Lock supervisor for the display MMCM.
// Runs on the free-running board clock. It pulses the MMCM reset, waits for LOCKED,
// qualifies lock stability, and retries failed attempts. It raises a sticky fault
// once the retry budget is used up.
module display_clock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_locked,
  input  logic       i_restart,
  output logic       o_mmcm_rst,
  output logic       o_clk_ok,
  output logic       o_lost,
  output logic       o_fault,
  output logic [3:0] o_retries
);

  // One shared counter, sized for the longest of the three intervals.
  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  // Each interval ends on the edge where the counter holds its last value (N-1).
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retries_q, retries_d;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic             fail;
  logic             mmcm_rst_q, mmcm_rst_d;
  logic             clk_ok_q, clk_ok_d;
  logic             lost_q, lost_d;
  logic             fault_q, fault_d;

  assign locked_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous MMCM LOCKED signal.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_locked};
    end
  end

  // Next state, counter, retry count and registered output values.
  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    lost_d    = 1'b0;
    fail      = 1'b0;

    unique case (state_q)
      ST_RESET: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_WAIT_LOCK: begin
        if (locked_s)                   state_d = ST_STABLE;
        else if (cnt_q == TIMEOUT_LAST) fail    = 1'b1;
        else                            cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_STABLE: begin
        if (!locked_s)                 fail    = 1'b1;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
        else                           cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_RUN: begin
        // A lock drop while running re-arms the sequence and is not counted as a retry.
        if (!locked_s) begin
          state_d = ST_RESET;
          lost_d  = 1'b1;
        end
      end
      ST_FAULT: ;
      default: state_d = ST_RESET;
    endcase

    // A failed attempt bumps the saturating retry count and may exhaust the budget.
    if (fail) begin
      retries_d = (retries_q == 4'hF) ? 4'hF : retries_q + 4'd1;
      state_d   = (retries_d == RETRY_LIMIT) ? ST_FAULT : ST_RESET;
    end

    // A successful qualification forgets earlier failures.
    if (state_d == ST_RUN && state_q != ST_RUN) retries_d = 4'd0;

    // Restart overrides every event that coincides with it on the same edge.
    if (i_restart) begin
      state_d   = ST_RESET;
      retries_d = 4'd0;
      lost_d    = 1'b0;
    end

    if (state_d != state_q || i_restart) cnt_d = '0;

    mmcm_rst_d = (state_d == ST_RESET) || (state_d == ST_FAULT);
    clk_ok_d   = (state_d == ST_RUN);
    fault_d    = (state_d == ST_FAULT);
  end

  // State, counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      retries_q  <= 4'd0;
      mmcm_rst_q <= 1'b1;
      clk_ok_q   <= 1'b0;
      lost_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retries_q  <= retries_d;
      mmcm_rst_q <= mmcm_rst_d;
      clk_ok_q   <= clk_ok_d;
      lost_q     <= lost_d;
      fault_q    <= fault_d;
    end
  end

  assign o_mmcm_rst = mmcm_rst_q;
  assign o_clk_ok   = clk_ok_q;
  assign o_lost     = lost_q;
  assign o_fault    = fault_q;
  assign o_retries  = retries_q;

endmodule

// File: tb/tb_display_clock_supervisor.sv
// Directed bench for display_clock_supervisor.
// Parameters are reduced: reset 4, timeout 20, stable 8, retries 2.
// Edge numbers in comments count posedges after the named reference point.
module tb_display_clock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       locked    = 1'b0;
  logic       restart   = 1'b0;
  logic       mmcm_rst;
  logic       clk_ok;
  logic       lost;
  logic       fault;
  logic [3:0] retries;

  int n_cmp = 0;
  int n_mis = 0;

  display_clock_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_locked  (locked),
    .i_restart (restart),
    .o_mmcm_rst(mmcm_rst),
    .o_clk_ok  (clk_ok),
    .o_lost    (lost),
    .o_fault   (fault),
    .o_retries (retries)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".mmcm_rst"}, 32'(mmcm_rst), 32'd1);
    check({tag, ".clk_ok"},   32'(clk_ok),   32'd0);
    check({tag, ".lost"},     32'(lost),     32'd0);
    check({tag, ".fault"},    32'(fault),    32'd0);
    check({tag, ".retries"},  32'(retries),  32'd0);
  endtask

  // Assert reset asynchronously mid-cycle with the lock input low.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    locked = 1'b0;
    #1;
    check_reset_values(tag);
    tick(2);
  endtask

  // Release reset, then raise the lock 10 clocks later. The reset pulse lasts 4 edges.
  // o_clk_ok rises 3 + STABLE_CYCLES = 11 edges after the lock rises.
  task automatic nominal_lock(input string tag);
    check_reset_values({tag, ".held"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(3);                                         // edge 3
    check({tag, ".rst_e3"}, 32'(mmcm_rst), 32'd1);
    tick(1);                                         // edge 4
    check({tag, ".rst_e4"}, 32'(mmcm_rst), 32'd0);
    tick(6);                                         // edge 10
    locked = 1'b1;
    tick(10);                                        // edge 20
    check({tag, ".ok_e20"}, 32'(clk_ok), 32'd0);
    tick(1);                                         // edge 21
    check({tag, ".ok_e21"}, 32'(clk_ok), 32'd1);
    check({tag, ".retries"}, 32'(retries), 32'd0);
    check({tag, ".rst_run"}, 32'(mmcm_rst), 32'd0);
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    tick(2);

    // Scenario 1: nominal lock from power-up.
    nominal_lock("s1");

    // Scenario 4: lock loss in RUN. The drop is applied after edge D.
    tick(2);
    locked = 1'b0;
    tick(2);                                         // D+2
    check("s4.ok_d2", 32'(clk_ok), 32'd1);
    check("s4.lost_d2", 32'(lost), 32'd0);
    tick(1);                                         // D+3
    check("s4.ok_d3", 32'(clk_ok), 32'd0);
    check("s4.lost_d3", 32'(lost), 32'd1);
    check("s4.rst_d3", 32'(mmcm_rst), 32'd1);
    check("s4.retries", 32'(retries), 32'd0);
    tick(1);                                         // D+4
    check("s4.lost_d4", 32'(lost), 32'd0);
    tick(2);                                         // D+6
    check("s4.rst_d6", 32'(mmcm_rst), 32'd1);
    tick(1);                                         // D+7: WAIT_LOCK entered, call this W
    check("s4.rst_d7", 32'(mmcm_rst), 32'd0);
    check("s4.retries_end", 32'(retries), 32'd0);

    // Scenario 3: the lock is high 5 clocks, low 3 clocks, then high again.
    locked = 1'b1;
    tick(5);                                         // W+5
    locked = 1'b0;
    tick(2);                                         // W+7
    check("s3.retries_w7", 32'(retries), 32'd0);
    tick(1);                                         // W+8: locked_s low seen in STABLE
    check("s3.retries_w8", 32'(retries), 32'd1);
    check("s3.rst_w8", 32'(mmcm_rst), 32'd1);
    check("s3.ok_w8", 32'(clk_ok), 32'd0);
    locked = 1'b1;
    tick(3);                                         // W+11
    check("s3.rst_w11", 32'(mmcm_rst), 32'd1);
    tick(1);                                         // W+12
    check("s3.rst_w12", 32'(mmcm_rst), 32'd0);
    tick(8);                                         // W+20
    check("s3.ok_w20", 32'(clk_ok), 32'd0);
    tick(1);                                         // W+21
    check("s3.ok_w21", 32'(clk_ok), 32'd1);
    check("s3.retries_run", 32'(retries), 32'd0);

    // Scenario 6: async reset in RUN, then the nominal sequence again.
    tick(3);
    async_reset("s6.async");
    nominal_lock("s6");

    // Scenario 2: lock held low until two timeouts exhaust the budget.
    async_reset("s2.async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(4);                                         // edge 4
    check("s2.rst_e4", 32'(mmcm_rst), 32'd0);
    tick(19);                                        // edge 23
    check("s2.retries_e23", 32'(retries), 32'd0);
    check("s2.rst_e23", 32'(mmcm_rst), 32'd0);
    tick(1);                                         // edge 24: first timeout
    check("s2.retries_e24", 32'(retries), 32'd1);
    check("s2.rst_e24", 32'(mmcm_rst), 32'd1);
    tick(4);                                         // edge 28
    check("s2.rst_e28", 32'(mmcm_rst), 32'd0);
    tick(19);                                        // edge 47
    check("s2.retries_e47", 32'(retries), 32'd1);
    check("s2.fault_e47", 32'(fault), 32'd0);
    tick(1);                                         // edge 48: second timeout
    check("s2.fault_e48", 32'(fault), 32'd1);
    check("s2.retries_e48", 32'(retries), 32'd2);
    check("s2.rst_e48", 32'(mmcm_rst), 32'd1);
    check("s2.ok_e48", 32'(clk_ok), 32'd0);
    locked = 1'b1;
    tick(40);
    check("s2.fault_hold", 32'(fault), 32'd1);
    check("s2.rst_hold", 32'(mmcm_rst), 32'd1);
    check("s2.ok_hold", 32'(clk_ok), 32'd0);
    check("s2.retries_hold", 32'(retries), 32'd2);
    locked = 1'b0;
    tick(3);                                         // F

    // Scenario 5: restart out of FAULT, then a restart coinciding with a timeout.
    restart = 1'b1;
    tick(1);                                         // F+1
    restart = 1'b0;
    check("s5.fault_f1", 32'(fault), 32'd0);
    check("s5.retries_f1", 32'(retries), 32'd0);
    check("s5.rst_f1", 32'(mmcm_rst), 32'd1);
    tick(3);                                         // F+4
    check("s5.rst_f4", 32'(mmcm_rst), 32'd1);
    tick(1);                                         // F+5
    check("s5.rst_f5", 32'(mmcm_rst), 32'd0);
    tick(19);                                        // F+24
    check("s5.rst_f24", 32'(mmcm_rst), 32'd0);
    restart = 1'b1;
    tick(1);                                         // F+25: timeout edge and restart together
    restart = 1'b0;
    check("s5.retries_f25", 32'(retries), 32'd0);
    check("s5.fault_f25", 32'(fault), 32'd0);
    check("s5.rst_f25", 32'(mmcm_rst), 32'd1);
    tick(3);                                         // F+28
    check("s5.rst_f28", 32'(mmcm_rst), 32'd1);
    tick(1);                                         // F+29
    check("s5.rst_f29", 32'(mmcm_rst), 32'd0);
    tick(19);                                        // F+48
    check("s5.retries_f48", 32'(retries), 32'd0);
    tick(1);                                         // F+49: first counted timeout
    check("s5.retries_f49", 32'(retries), 32'd1);
    check("s5.fault_f49", 32'(fault), 32'd0);
    check("s5.rst_f49", 32'(mmcm_rst), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
